// File: rtl/icache_2way.sv
// Two-way set-associative VIPT instruction cache: 256 sets x 2 ways x 16-byte lines.
// Stage 1 reads the arrays; stage 2 does tag compare, CACOP handling and miss/refill sequencing.
module icache_2way (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] icache_idx,
  input  logic [2:0]  icache_op,
  input  logic [31:0] icache_pa,
  input  logic        icache_is_cached,
  input  logic        icache_stall,
  input  logic        icache_flush,
  output logic        icache_ready,
  output logic [31:0] icache_data,
  output logic        rd_req,
  output logic        rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
);

  localparam logic [2:0] OP_FETCH  = 3'b001;
  localparam logic [2:0] OP_IDXINV = 3'b010;
  localparam logic [2:0] OP_HITINV = 3'b011;

  typedef enum logic [1:0] {S_LOOKUP, S_MISS, S_REFILL, S_DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_busy;
  logic [31:0] r_pa;
  logic [2:0]  r_op;
  logic        r_cached;
  logic [11:0] r_idx;
  logic        r_kill;
  logic        r_victim;
  logic [1:0]  r_beat;
  logic [31:0] r_buf [4];

  logic [255:0] r_vld [2];
  logic [255:0] r_lru;
  logic [19:0]  r_tagArr [2][256];
  logic [31:0]  r_dataArr [2][256][4];
  logic [19:0]  r_tagRd [2];
  logic [31:0]  r_wordRd [2];

  logic [7:0]  w_set;
  logic [1:0]  w_word;
  logic [19:0] w_tag;
  logic        w_hit0;
  logic        w_hit1;
  logic        w_hit;
  logic        w_hitWay;
  logic        w_isFetch;
  logic        w_isCacop;
  logic        w_reqOp;
  logic        w_accept;
  logic        w_refillLast;
  logic        w_ready;
  logic [31:0] w_data;
  logic        w_leave;
  logic        w_lruWr;
  logic        w_lruVal;
  logic        w_invWr;
  logic        w_invWay;
  logic        w_unused;

  assign w_set        = r_idx[11:4];
  assign w_word       = r_idx[3:2];
  assign w_tag        = r_pa[31:12];
  assign w_unused     = r_idx[1];
  assign w_hit0       = r_vld[0][w_set] && (r_tagRd[0] == w_tag);
  assign w_hit1       = r_vld[1][w_set] && (r_tagRd[1] == w_tag);
  assign w_hit        = w_hit0 || w_hit1;
  assign w_hitWay     = !w_hit0;
  assign w_isFetch    = (r_op == OP_FETCH);
  assign w_isCacop    = (r_op == OP_IDXINV) || (r_op == OP_HITINV);
  assign w_reqOp      = (icache_op == OP_FETCH) || (icache_op == OP_IDXINV) ||
                        (icache_op == OP_HITINV);
  assign w_refillLast = (r_state == S_REFILL) && ret_valid && ret_last;
  assign w_accept     = w_reqOp && !icache_stall && !icache_flush && (!r_busy || w_ready);

  // Valid bits are flops read with the stage-2 set, so an invalidate is visible to the very next lookup
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_data      = 32'h0;
    w_leave     = 1'b0;
    w_lruWr     = 1'b0;
    w_lruVal    = 1'b0;
    w_invWr     = 1'b0;
    w_invWay    = 1'b0;
    unique case (r_state)
      S_LOOKUP: begin
        if (r_busy) begin
          if (w_isFetch && r_cached && w_hit) begin
            w_ready = !icache_flush;
            w_data  = r_wordRd[w_hitWay];
          end else if (w_isCacop) begin
            w_ready = !icache_flush;
          end
          if (w_isCacop && (icache_flush || !icache_stall)) begin
            w_invWr  = (r_op == OP_IDXINV) || w_hit;
            w_invWay = (r_op == OP_IDXINV) ? r_idx[0] : w_hitWay;
          end
          if (icache_flush) begin
            w_leave = 1'b1;
          end else if (!icache_stall) begin
            if (w_isFetch && r_cached && w_hit) begin
              w_lruWr  = 1'b1;
              w_lruVal = !w_hitWay;
              w_leave  = 1'b1;
            end else if (w_isFetch) begin
              w_nextState = S_MISS;
            end else begin
              w_leave = 1'b1;
            end
          end
        end
      end
      S_MISS: begin
        if (rd_rdy) w_nextState = S_REFILL;
      end
      S_REFILL: begin
        if (w_refillLast) w_nextState = S_DONE;
      end
      S_DONE: begin
        w_ready = !r_kill && !icache_flush;
        w_data  = r_cached ? r_buf[w_word] : r_buf[0];
        if (icache_flush || r_kill || !icache_stall) begin
          w_nextState = S_LOOKUP;
          w_leave     = 1'b1;
        end
      end
      default: w_nextState = S_LOOKUP;
    endcase
  end

  assign icache_ready = w_ready;
  assign icache_data  = w_ready ? w_data : 32'h0;
  assign rd_req       = (r_state == S_MISS);
  assign rd_type      = rd_req && r_cached;
  assign rd_addr      = rd_req ? (r_cached ? {r_pa[31:4], 4'h0} : r_pa) : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_LOOKUP;
      r_busy   <= 1'b0;
      r_pa     <= 32'h0;
      r_op     <= 3'b000;
      r_cached <= 1'b0;
      r_idx    <= 12'h0;
      r_kill   <= 1'b0;
      r_victim <= 1'b0;
      r_beat   <= 2'd0;
      r_vld[0] <= '0;
      r_vld[1] <= '0;
      r_lru    <= '0;
      for (int i = 0; i < 4; i++) r_buf[i] <= 32'h0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_pa     <= icache_pa;
        r_op     <= icache_op;
        r_cached <= icache_is_cached;
        r_idx    <= icache_idx;
      end else if (w_leave) begin
        r_busy <= 1'b0;
      end
      if ((r_state == S_LOOKUP) && (w_nextState == S_MISS)) r_victim <= r_lru[w_set];
      // A flush during the bus transaction lets it finish but suppresses the DONE response
      if (((r_state == S_MISS) || (r_state == S_REFILL)) && icache_flush) begin
        r_kill <= 1'b1;
      end else if ((r_state == S_DONE) && w_leave) begin
        r_kill <= 1'b0;
      end
      if ((r_state == S_REFILL) && ret_valid) begin
        r_buf[r_beat] <= ret_data;
        r_beat        <= ret_last ? 2'd0 : r_beat + 2'd1;
      end
      if (w_lruWr) r_lru[w_set] <= w_lruVal;
      if (w_invWr) r_vld[w_invWay][w_set] <= 1'b0;
      if (w_refillLast && r_cached) begin
        r_vld[r_victim][w_set] <= 1'b1;
        r_lru[w_set]           <= ~r_victim;
      end
    end
  end

  // Tag/data storage is plain RAM: synchronous read on acceptance, line write on the last refill beat
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int w = 0; w < 2; w++) begin
        r_tagRd[w]  <= r_tagArr[w][icache_idx[11:4]];
        r_wordRd[w] <= r_dataArr[w][icache_idx[11:4]][icache_idx[3:2]];
      end
    end
    if (rst_n && w_refillLast && r_cached) begin
      r_tagArr[r_victim][w_set] <= w_tag;
      for (int i = 0; i < 4; i++) begin
        r_dataArr[r_victim][w_set][i] <= (r_beat == 2'(i)) ? ret_data : r_buf[i];
      end
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Self-checking bench for icache_2way: a bus responder model plus a scoreboard of expected
// fetch results, with one task per scenario checking latency, bus traffic and flush/stall rules.
module tb_icache_2way;

  localparam logic [2:0] OP_NONE   = 3'b000;
  localparam logic [2:0] OP_FETCH  = 3'b001;
  localparam logic [2:0] OP_IDXINV = 3'b010;
  localparam logic [2:0] OP_HITINV = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] icache_idx;
  logic [2:0]  icache_op;
  logic [31:0] icache_pa;
  logic        icache_is_cached;
  logic        icache_stall;
  logic        icache_flush;
  logic        icache_ready;
  logic [31:0] icache_data;
  logic        rd_req;
  logic        rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;

  int          nAssert = 0;
  int          nFail = 0;
  logic [31:0] expQ[$];
  int          reqCount = 0;
  logic [31:0] lastAddr = 32'h0;
  logic        lastType = 1'b0;
  int          busBeat = -1;

  always #5 clk = ~clk;

  icache_2way dut (
    .clk(clk),
    .rst_n(rst_n),
    .icache_idx(icache_idx),
    .icache_op(icache_op),
    .icache_pa(icache_pa),
    .icache_is_cached(icache_is_cached),
    .icache_stall(icache_stall),
    .icache_flush(icache_flush),
    .icache_ready(icache_ready),
    .icache_data(icache_data),
    .rd_req(rd_req),
    .rd_type(rd_type),
    .rd_addr(rd_addr),
    .rd_rdy(rd_rdy),
    .ret_valid(ret_valid),
    .ret_last(ret_last),
    .ret_data(ret_data)
  );

  // Backing memory contents seen through the bus
  function automatic logic [31:0] memFn(input logic [31:0] a);
    case (a)
      32'h1C00_0000: memFn = 32'h0000_00A0;
      32'h1C00_0004: memFn = 32'h0000_00A1;
      32'h1C00_0008: memFn = 32'h0000_00A2;
      32'h1C00_000C: memFn = 32'h0000_00A3;
      32'h1FE0_0010: memFn = 32'h0000_DEAD;
      default:       memFn = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Bus responder: single-cycle rd_rdy, then back-to-back return beats
  initial begin
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    forever begin
      @(negedge clk);
      rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
      if (rst_n === 1'b1 && rd_req === 1'b1) begin
        rd_rdy   = 1'b1;
        lastAddr = rd_addr;
        lastType = rd_type;
        reqCount++;
        @(negedge clk);
        rd_rdy = 1'b0;
        for (int b = 0; b < (lastType ? 4 : 1); b++) begin
          ret_valid = 1'b1;
          ret_last  = (b == (lastType ? 3 : 0));
          ret_data  = memFn(lastAddr + 32'(4 * b));
          busBeat   = b;
          @(negedge clk);
        end
        ret_valid = 1'b0; ret_last = 1'b0; busBeat = -1;
      end
    end
  end

  // Scoreboard: every consumed response (ready while not stalled) pops one expectation
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk); #3;
      if (rst_n === 1'b1 && icache_ready === 1'b1 && icache_stall === 1'b0) begin
        nAssert++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected_ready: data=%h with no expected response", icache_data);
        end else begin
          exp = expQ.pop_front();
          if (icache_data !== exp) begin
            nFail++;
            $display("[TB] FAIL scoreboard_data: got %h expected %h", icache_data, exp);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic applyStimulus(input logic [11:0] idx, input logic [31:0] pa,
                               input logic cached, input logic [2:0] op);
    icache_idx = idx; icache_pa = pa; icache_is_cached = cached; icache_op = op;
  endtask

  // Issue one request into an idle or just-answered stage 2 and report cycles to ready (-1 on timeout)
  task automatic doReq(input logic [11:0] idx, input logic [31:0] pa, input logic cached,
                       input logic [2:0] op, input logic [31:0] expData, output int cycles);
    expQ.push_back(expData);
    applyStimulus(idx, pa, cached, op);
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) icache_op = OP_NONE;
      if (icache_ready === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(12'h0, 32'h0, 1'b0, OP_NONE);
    icache_stall = 1'b0; icache_flush = 1'b0;
    repeat (3) tick();
    nAssert++; if (icache_ready !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ready: got %b expected 0", icache_ready); end
    nAssert++; if (icache_data !== 32'h0) begin nFail++; $display("[TB] FAIL reset_data: got %h expected 0", icache_data); end
    nAssert++; if (rd_req !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rd_req: got %b expected 0", rd_req); end
    nAssert++; if (rd_type !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rd_type: got %b expected 0", rd_type); end
    nAssert++; if (rd_addr !== 32'h0) begin nFail++; $display("[TB] FAIL reset_rd_addr: got %h expected 0", rd_addr); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_cold_fetch();
    int c;
    int r0 = reqCount;
    doReq(12'h004, 32'h1C00_0004, 1'b1, OP_FETCH, 32'h0000_00A1, c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL cold_latency: got %0d expected 7", c); end
    nAssert++; if (reqCount - r0 !== 1) begin nFail++; $display("[TB] FAIL cold_req_count: got %0d expected 1", reqCount - r0); end
    nAssert++; if (lastAddr !== 32'h1C00_0000) begin nFail++; $display("[TB] FAIL cold_rd_addr: got %h expected 1c000000", lastAddr); end
    nAssert++; if (lastType !== 1'b1) begin nFail++; $display("[TB] FAIL cold_rd_type: got %b expected 1", lastType); end
  endtask

  task automatic test_repeat_fetch();
    int c;
    int r0 = reqCount;
    doReq(12'h00C, 32'h1C00_000C, 1'b1, OP_FETCH, 32'h0000_00A3, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL repeat_latency: got %0d expected 1", c); end
    nAssert++; if (reqCount !== r0) begin nFail++; $display("[TB] FAIL repeat_no_req: got %0d requests expected 0", reqCount - r0); end
  endtask

  task automatic test_lru();
    int c;
    doReq(12'h000, 32'h2C00_0000, 1'b1, OP_FETCH, memFn(32'h2C00_0000), c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL lru_fill_way1: got latency %0d expected 7", c); end
    doReq(12'h000, 32'h1C00_0000, 1'b1, OP_FETCH, 32'h0000_00A0, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL lru_hit_way0: got latency %0d expected 1", c); end
    doReq(12'h000, 32'h3C00_0000, 1'b1, OP_FETCH, memFn(32'h3C00_0000), c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL lru_miss_3c: got latency %0d expected 7", c); end
    doReq(12'h008, 32'h1C00_0008, 1'b1, OP_FETCH, 32'h0000_00A2, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL lru_keep_1c: got latency %0d expected 1", c); end
    doReq(12'h000, 32'h2C00_0000, 1'b1, OP_FETCH, memFn(32'h2C00_0000), c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL lru_evicted_2c: got latency %0d expected 7", c); end
  endtask

  task automatic test_uncached();
    int c;
    int r0 = reqCount;
    doReq(12'h010, 32'h1FE0_0010, 1'b0, OP_FETCH, 32'h0000_DEAD, c);
    nAssert++; if (c !== 4) begin nFail++; $display("[TB] FAIL uncached_latency: got %0d expected 4", c); end
    nAssert++; if (lastType !== 1'b0) begin nFail++; $display("[TB] FAIL uncached_rd_type: got %b expected 0", lastType); end
    nAssert++; if (lastAddr !== 32'h1FE0_0010) begin nFail++; $display("[TB] FAIL uncached_rd_addr: got %h expected 1fe00010", lastAddr); end
    doReq(12'h010, 32'h1FE0_0010, 1'b0, OP_FETCH, 32'h0000_DEAD, c);
    nAssert++; if (c !== 4) begin nFail++; $display("[TB] FAIL uncached_refetch_latency: got %0d expected 4", c); end
    nAssert++; if (reqCount - r0 !== 2) begin nFail++; $display("[TB] FAIL uncached_req_count: got %0d expected 2", reqCount - r0); end
  endtask

  task automatic test_cacop();
    int c;
    doReq(12'h000, 32'h1C00_0000, 1'b1, OP_HITINV, 32'h0, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL hitinv_latency: got %0d expected 1", c); end
    doReq(12'h004, 32'h1C00_0004, 1'b1, OP_FETCH, 32'h0000_00A1, c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL hitinv_then_miss: got latency %0d expected 7", c); end
    doReq(12'h001, 32'h0, 1'b1, OP_IDXINV, 32'h0, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL idxinv_latency: got %0d expected 1", c); end
    doReq(12'h000, 32'h1C00_0000, 1'b1, OP_FETCH, 32'h0000_00A0, c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL idxinv_way0_kept: got latency %0d expected 1", c); end
    doReq(12'h000, 32'h2C00_0000, 1'b1, OP_FETCH, memFn(32'h2C00_0000), c);
    nAssert++; if (c !== 7) begin nFail++; $display("[TB] FAIL idxinv_way1_cleared: got latency %0d expected 7", c); end
  endtask

  task automatic test_flush_lookup();
    int r0 = reqCount;
    int rdy = 0;
    applyStimulus(12'h020, 32'h1FE0_0020, 1'b0, OP_FETCH);
    tick();
    icache_op = OP_NONE;
    icache_flush = 1'b1;
    tick();
    icache_flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (icache_ready === 1'b1) rdy++;
    end
    nAssert++; if (rdy !== 0) begin nFail++; $display("[TB] FAIL flush_lookup_ready: got %0d ready cycles expected 0", rdy); end
    nAssert++; if (reqCount !== r0) begin nFail++; $display("[TB] FAIL flush_lookup_no_req: got %0d requests expected 0", reqCount - r0); end
  endtask

  task automatic test_flush_refill();
    int c;
    int r0 = reqCount;
    int rdy = 0;
    bit found = 0;
    applyStimulus(12'h010, 32'h1C00_0010, 1'b1, OP_FETCH);
    tick();
    icache_op = OP_NONE;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busBeat == 2 && ret_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    nAssert++; if (found !== 1'b1) begin nFail++; $display("[TB] FAIL flush_refill_beat2: got found=%0d expected 1", found); end
    icache_flush = 1'b1;
    tick();
    icache_flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (icache_ready === 1'b1) rdy++;
    end
    nAssert++; if (rdy !== 0) begin nFail++; $display("[TB] FAIL flush_refill_ready: got %0d ready cycles expected 0", rdy); end
    nAssert++; if (reqCount - r0 !== 1) begin nFail++; $display("[TB] FAIL flush_refill_req: got %0d requests expected 1", reqCount - r0); end
    doReq(12'h014, 32'h1C00_0014, 1'b1, OP_FETCH, memFn(32'h1C00_0014), c);
    nAssert++; if (c !== 1) begin nFail++; $display("[TB] FAIL flush_refill_line_valid: got latency %0d expected 1", c); end
  endtask

  task automatic test_stall();
    logic [31:0] exp = memFn(32'h1C00_0014);
    expQ.push_back(exp);
    applyStimulus(12'h014, 32'h1C00_0014, 1'b1, OP_FETCH);
    tick();
    nAssert++; if (icache_ready !== 1'b1) begin nFail++; $display("[TB] FAIL stall_first_ready: got %b expected 1", icache_ready); end
    icache_stall = 1'b1;
    applyStimulus(12'h018, 32'h1C00_0018, 1'b1, OP_FETCH);
    for (int i = 0; i < 3; i++) begin
      nAssert++;
      if ({icache_ready, icache_data} !== {1'b1, exp}) begin
        nFail++;
        $display("[TB] FAIL stall_hold_%0d: got ready=%b data=%h expected ready=1 data=%h", i, icache_ready, icache_data, exp);
      end
      tick();
    end
    icache_stall = 1'b0;
    icache_op = OP_NONE;
    tick();
    nAssert++; if (icache_ready !== 1'b0) begin nFail++; $display("[TB] FAIL stall_no_accept: got ready=%b expected 0", icache_ready); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] idxs [3] = '{12'h008, 12'h00C, 12'h014};
    logic [31:0] pas  [3] = '{32'h1C00_0008, 32'h2C00_000C, 32'h1C00_0014};
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(memFn(pas[i]));
      applyStimulus(idxs[i], pas[i], 1'b1, OP_FETCH);
      tick();
      nAssert++; if (icache_ready !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_ready_%0d: got %b expected 1", i, icache_ready); end
    end
    icache_op = OP_NONE;
    tick();
    nAssert++; if (icache_ready !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_idle: got %b expected 0", icache_ready); end
  endtask

  task automatic checkOutput();
    repeat (3) tick();
    nAssert++; if (expQ.size() !== 0) begin nFail++; $display("[TB] FAIL scoreboard_leftover: got %0d pending expected 0", expQ.size()); end
  endtask

  initial begin
    $display("[TB] starting icache_2way bench");
    test_reset();
    test_cold_fetch();
    test_repeat_fetch();
    test_lru();
    test_uncached();
    test_cacop();
    test_flush_lookup();
    test_flush_refill();
    test_stall();
    test_back_to_back();
    checkOutput();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
